// File: rtl/cmd_dispatcher_pkg.sv
// Shared defines for the command path: command word seen by the queue and
// the PE array, plus the dispatcher FSM state encoding.
package cmd_dispatcher_pkg;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] dst;
      logic [7:0] imm;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH    = 2'd1,
      ST_LOAD     = 2'd2,
      ST_DISPATCH = 2'd3
   } disp_state_t;

endpackage

// File: rtl/cmd_dispatcher_if.sv
// Queue read port and PE array signals seen by the dispatcher.
// master = dispatcher side, slave = queue/PE-array side.
interface cmd_dispatcher_if #(
   parameter int NUM_PE = 4
);
   import cmd_dispatcher_pkg::*;

   logic              i_fifo_empty;
   cmd_t              i_fifo_data;
   logic              o_fifo_read;
   logic [NUM_PE-1:0] o_pe_valid;
   cmd_t              o_pe_cmd;
   logic [NUM_PE-1:0] i_pe_done;
   logic [NUM_PE-1:0] o_pe_busy;

   modport master (
      input  i_fifo_empty, i_fifo_data, i_pe_done,
      output o_fifo_read, o_pe_valid, o_pe_cmd, o_pe_busy
   );

   modport slave (
      output i_fifo_empty, i_fifo_data, i_pe_done,
      input  o_fifo_read, o_pe_valid, o_pe_cmd, o_pe_busy
   );

endinterface

// File: rtl/cmd_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int LW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  gnt
);

   logic found;
   int   idx;

   // scan from last+1 upward so the most recent winner has lowest priority
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last) + i) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cmd_dispatcher.sv
// Pops one command at a time from the queue and hands it to a free PE,
// round-robin, tracking per-PE busy until the PE reports done.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | wait for a queued command and at least one free PE
// ST_FETCH    | o_fifo_read high for one cycle (pop)
// ST_LOAD     | queue head valid; capture into cmd_q, pre-compute grant
// ST_DISPATCH | o_pe_valid strobe, mark PE busy, bump counter
module cmd_dispatcher #(
   parameter int NUM_PE = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   cmd_dispatcher_if.master     bus,
   output logic                 o_idle,
   output logic [CNT_W-1:0]     o_dispatch_count
);
   import cmd_dispatcher_pkg::*;

   localparam int IDX_W = $clog2(NUM_PE);

   disp_state_t       state_q;
   logic [NUM_PE-1:0] busy_q;
   logic [NUM_PE-1:0] busy_d;
   logic [NUM_PE-1:0] free_d;
   logic [NUM_PE-1:0] valid_q;
   logic [NUM_PE-1:0] gnt;
   logic [IDX_W-1:0]  last_q;
   logic [IDX_W-1:0]  gnt_idx;
   cmd_t              cmd_q;
   logic              fifo_read_q;
   logic              idle_q;
   logic [CNT_W-1:0]  cnt_q;

   // valid_q is non-zero only in DISPATCH, so it doubles as the grant being
   // applied this edge; a grant beats a same-cycle done on that PE
   always_comb begin
      busy_d = (busy_q & ~bus.i_pe_done) | valid_q;
      free_d = ~busy_d;
   end

   // In LOAD no grant is pending, so busy_d is exactly the busy set the
   // DISPATCH cycle will see; arbitrating on it lets the strobe be registered.
   rr_arbiter #(.N(NUM_PE)) u_arb (
      .req  (free_d),
      .last (last_q),
      .gnt  (gnt)
   );

   // index of the one-hot grant currently on the strobe
   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         if (valid_q[k]) gnt_idx = IDX_W'(k);
      end
   end

   // dispatcher FSM with registered outputs and busy/last/counter tracking
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         busy_q      <= '0;
         last_q      <= IDX_W'(NUM_PE - 1);
         cmd_q       <= '0;
         fifo_read_q <= 1'b0;
         valid_q     <= '0;
         idle_q      <= 1'b1;
         cnt_q       <= '0;
      end else begin
         busy_q      <= busy_d;
         fifo_read_q <= 1'b0;
         valid_q     <= '0;
         case (state_q)
            ST_IDLE: begin
               if (!bus.i_fifo_empty && |(~busy_q)) begin
                  state_q     <= ST_FETCH;
                  fifo_read_q <= 1'b1;
                  idle_q      <= 1'b0;
               end else begin
                  idle_q      <= ~|busy_d;
               end
            end
            ST_FETCH: begin
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               cmd_q   <= bus.i_fifo_data;
               valid_q <= gnt;
               state_q <= ST_DISPATCH;
            end
            ST_DISPATCH: begin
               last_q  <= gnt_idx;
               cnt_q   <= cnt_q + CNT_W'(1);
               state_q <= ST_IDLE;
               idle_q  <= ~|busy_d;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_fifo_read = fifo_read_q;
   assign bus.o_pe_valid  = valid_q;
   assign bus.o_pe_cmd    = cmd_q;
   assign bus.o_pe_busy   = busy_q;
   assign o_idle          = idle_q;
   assign o_dispatch_count = cnt_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: FIFO model drives the queue side, a monitor
// scoreboards every dispatch against a queue/array reference model.
module tb_cmd_dispatcher;
   import cmd_dispatcher_pkg::*;

   localparam int NP = 4;
   localparam int CW = 4;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          o_idle;
   logic [CW-1:0] o_cnt;

   cmd_dispatcher_if #(.NUM_PE(NP)) bus();

   cmd_dispatcher #(.NUM_PE(NP), .CNT_W(CW)) dut (
      .i_clk            (clk),
      .i_rstn           (rstn),
      .bus              (bus),
      .o_idle           (o_idle),
      .o_dispatch_count (o_cnt)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   int   reads = 0;
   int   ndisp = 0;
   cmd_t fifo_q[$];
   cmd_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic cmd_t rnd_cmd();
      logic [15:0] r;
      r = 16'($urandom);
      return r;
   endfunction

   // first free PE after 'last', wrapping; -1 if none
   function automatic int rr_pick(input logic [NP-1:0] busy, input int last);
      for (int i = 1; i <= NP; i++) begin
         int k;
         k = (last + i) % NP;
         if (!busy[k]) return k;
      end
      return -1;
   endfunction

   task automatic push(input cmd_t c);
      fifo_q.push_back(c);
      bus.i_fifo_empty = 1'b0;
   endtask

   // one clock: done applied at negedge, queue pop serviced just after posedge
   task automatic tick(input logic [NP-1:0] done);
      @(negedge clk);
      bus.i_pe_done = done;
      @(posedge clk);
      #1;
      if (bus.o_fifo_read) begin
         reads++;
         if (fifo_q.size() > 0) begin
            bus.i_fifo_data = fifo_q.pop_front();
            exp_q.push_back(bus.i_fifo_data);
         end
      end
      if (bus.o_pe_valid != '0) ndisp++;
      bus.i_fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      bus.i_pe_done = '0;
      fifo_q.delete();
      bus.i_fifo_empty = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_read"},  32'(bus.o_fifo_read), 0);
      chk({tag, "_valid"}, 32'(bus.o_pe_valid), 0);
      chk({tag, "_cmd"},   32'(bus.o_pe_cmd), 0);
      chk({tag, "_busy"},  32'(bus.o_pe_busy), 0);
      chk({tag, "_cnt"},   32'(o_cnt), 0);
      chk({tag, "_idle"},  32'(o_idle), 1);
   endtask

   // monitor / scoreboard
   initial begin
      logic [NP-1:0] mb;
      logic [NP-1:0] pend;
      int   mlast, mcnt, cyc, rd_cyc, g;
      logic prev_empty, prev_read;
      cmd_t e;
      mb = '0; pend = '0; mlast = NP - 1; mcnt = 0; cyc = 0; rd_cyc = -100;
      prev_empty = 1'b1; prev_read = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (!rstn) begin
            mb = '0; pend = '0; mlast = NP - 1; mcnt = 0; rd_cyc = -100;
            prev_empty = 1'b1; prev_read = 1'b0;
            exp_q.delete();
            continue;
         end
         mb = (mb & ~bus.i_pe_done) | pend;
         if (pend != '0) mcnt = (mcnt + 1) % (1 << CW);
         pend = '0;
         chk("mon_busy", 32'(bus.o_pe_busy), 32'(mb));
         chk("mon_count", 32'(o_cnt), 32'(mcnt));
         if (bus.o_fifo_read) begin
            chk("read_while_empty", 32'(prev_empty), 0);
            chk("read_width", 32'(prev_read), 0);
            rd_cyc = cyc;
         end
         if (bus.o_pe_valid != '0) begin
            chk("valid_latency", 32'(cyc - rd_cyc), 2);
            if (exp_q.size() == 0) begin
               chk("valid_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               g = rr_pick(mb, mlast);
               if (g < 0) begin
                  chk("free_pe_exists", 0, 1);
               end else begin
                  chk("grant", 32'(bus.o_pe_valid), 32'(1 << g));
                  chk("pe_cmd", 32'(bus.o_pe_cmd), 32'(e));
                  pend  = NP'(1 << g);
                  mlast = g;
               end
            end
         end
         prev_empty = bus.i_fifo_empty;
         prev_read  = bus.o_fifo_read;
      end
   end

   // stimulus
   initial begin
      cmd_t a;
      int   guard;
      bus.i_fifo_empty = 1'b1;
      bus.i_fifo_data  = '0;
      bus.i_pe_done    = '0;

      // reset held with random inputs
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.i_fifo_empty = 1'($urandom);
         bus.i_fifo_data  = rnd_cmd();
         bus.i_pe_done    = NP'($urandom);
         @(posedge clk);
         #1;
         chk_reset_vals("rst_hold");
      end
      @(negedge clk);
      bus.i_fifo_empty = 1'b1;
      bus.i_pe_done    = '0;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("rst_rel");
      reads = 0;
      for (int i = 0; i < 6; i++) tick('0);
      chk("empty_no_read", 32'(reads), 0);
      chk("empty_idle", 32'(o_idle), 1);

      // single command
      a = 16'hA5C3;
      push(a);
      reads = 0;
      tick('0);
      chk("single_fetch_read", 32'(bus.o_fifo_read), 1);
      tick('0);
      chk("single_load_novalid", 32'(bus.o_pe_valid), 0);
      tick('0);
      chk("single_valid", 32'(bus.o_pe_valid), 32'h1);
      chk("single_cmd", 32'(bus.o_pe_cmd), 32'(a));
      tick('0);
      chk("single_busy", 32'(bus.o_pe_busy), 32'h1);
      chk("single_cnt", 32'(o_cnt), 1);
      chk("single_reads", 32'(reads), 1);

      // round-robin until saturation, then release PE2
      do_reset();
      for (int i = 0; i < 5; i++) push(rnd_cmd());
      for (int i = 0; i < 20; i++) tick('0);
      chk("sat_busy", 32'(bus.o_pe_busy), 32'hF);
      chk("sat_cnt", 32'(o_cnt), 4);
      chk("sat_fifo_left", 32'(fifo_q.size()), 1);
      chk("sat_idle", 32'(o_idle), 0);
      reads = 0;
      for (int i = 0; i < 4; i++) tick('0);
      chk("sat_no_read", 32'(reads), 0);
      tick(4'b0100);
      chk("rel_c1", 32'(bus.o_pe_valid), 0);
      tick('0);
      chk("rel_c2_read", 32'(bus.o_fifo_read), 1);
      tick('0);
      chk("rel_c3", 32'(bus.o_pe_valid), 0);
      tick('0);
      chk("rel_valid_pe2", 32'(bus.o_pe_valid), 32'h4);
      tick('0);
      chk("rel_busy", 32'(bus.o_pe_busy), 32'hF);
      chk("rel_cnt", 32'(o_cnt), 5);

      // done/grant collision and done on a free PE
      do_reset();
      push(rnd_cmd());
      repeat (4) tick('0);
      push(rnd_cmd());
      tick('0);
      tick('0);
      tick('0);
      chk("coll_valid", 32'(bus.o_pe_valid), 32'h2);
      tick(4'b0010);
      chk("coll_busy", 32'(bus.o_pe_busy), 32'h3);
      tick(4'b0100);
      chk("free_done_busy", 32'(bus.o_pe_busy), 32'h3);
      chk("free_done_valid", 32'(bus.o_pe_valid), 0);
      chk("free_done_read", 32'(bus.o_fifo_read), 0);
      chk("free_done_cnt", 32'(o_cnt), 2);

      // reset during LOAD
      do_reset();
      push(rnd_cmd());
      repeat (4) tick('0);
      chk("mid_pre_cnt", 32'(o_cnt), 1);
      push(rnd_cmd());
      tick('0);
      tick('0);
      rstn = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      ndisp = 0;
      for (int i = 0; i < 6; i++) tick('0);
      chk("mid_no_valid", 32'(ndisp), 0);

      // counter wrap: 17 dispatches on a 4-bit counter
      do_reset();
      for (int i = 0; i < 17; i++) push(rnd_cmd());
      ndisp = 0;
      guard = 0;
      while (ndisp < 17 && guard < 200) begin
         tick('1);
         guard++;
      end
      chk("wrap_ndisp", 32'(ndisp), 17);
      tick('1);
      chk("wrap_cnt", 32'(o_cnt), 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) push(rnd_cmd());
         if ($urandom_range(0, 2) == 0) tick(NP'($urandom));
         else tick('0);
      end
      guard = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && guard < 400) begin
         tick(NP'($urandom));
         guard++;
      end
      repeat (4) tick('1);
      chk("drain_left", 32'(fifo_q.size() + exp_q.size()), 0);
      chk("drain_idle", 32'(o_idle), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Consumer stage behind the command queue: pops one `cmd_t` at a time from the queue FIFO and hands it to a free SIMD processing element (PE). PE selection is round-robin. Per-PE busy tracking runs until the PE reports completion. The block sits between the queue's read port and the PE array, and is the only driver of the queue's `i_read`.

## Interface
Parameters:
- `NUM_PE`, 4: number of processing elements; 2..16.
- `CNT_W`, 16: width of the dispatch counter.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rstn`  in  1  reset: asynchronous, active-low.
- `i_fifo_empty`  in  1  queue empty flag.
- `i_fifo_data`  in  `$bits(cmd_t)`  queue head data; valid the cycle after `o_fifo_read`.
- `o_fifo_read`  out  1  single-cycle pop request to the queue.
- `o_pe_valid`  out  `NUM_PE`  one-hot dispatch strobe, one cycle wide.
- `o_pe_cmd`  out  `$bits(cmd_t)`  command broadcast to all PEs; meaningful when `o_pe_valid != 0`.
- `i_pe_done`  in  `NUM_PE`  per-PE completion pulse; a level is treated as repeated pulses.
- `o_pe_busy`  out  `NUM_PE`  per-PE busy flags.
- `o_idle`  out  1  high when state is IDLE and all PEs are free.
- `o_dispatch_count`  out  `CNT_W`  total commands dispatched.

## Operation
- The FSM has four states: IDLE, FETCH, LOAD, DISPATCH. It is encoded as a package enum.
- **IDLE → FETCH** when `!i_fifo_empty && |(~busy)`. Otherwise it stays in IDLE.
- **FETCH:** `o_fifo_read = 1`, which is a Moore output from this state only. Next state is LOAD, unconditionally.
- **LOAD:** the `cmd_q` register captures `i_fifo_data` at the end of the cycle. Next state is DISPATCH.
- **DISPATCH:**
  - `o_pe_valid = grant`, where `grant` is the round-robin pick among free PEs. The search starts at `last_grant + 1` and wraps modulo `NUM_PE`.
  - The same edge sets `busy[grant]`, sets `last_grant` to the granted index, and increments `o_dispatch_count`. Next state is IDLE.
- At least one PE is always free in DISPATCH. Only the dispatcher sets busy bits, and a free PE existed when FETCH was entered.
- `o_pe_cmd` is driven continuously from `cmd_q`.
- **Busy update, per PE:** `busy_next[k] = (busy[k] & ~i_pe_done[k]) | grant_now[k]`.
  - A done pulse on a PE that is not busy is ignored.
  - A done pulse on PE k in the same cycle that k is granted leaves k busy; the grant wins.
- `o_dispatch_count` wraps from `2^CNT_W-1` to 0 with no saturation.
- The pop is never retracted. If the FIFO claimed non-empty, the popped command is always dispatched.

## Timing
- **Reset values:** `o_fifo_read=0`, `o_pe_valid=0`, `o_pe_cmd=0`, `o_pe_busy=0`, `o_idle=1`, `o_dispatch_count=0`. State resets to IDLE and `last_grant` resets to `NUM_PE-1`, so the first grant goes to PE0.
- **Latency:** the condition is seen in IDLE at cycle t. FETCH is cycle t+1, LOAD is t+2, and the `o_pe_valid` strobe is at t+3.
- **Throughput:** at most one dispatch per 4 cycles.
- **All PEs busy with the queue non-empty:** the FSM stays in IDLE and does not read. It leaves IDLE the cycle after the first `i_pe_done` clears a busy bit.
- **Queue empty:** no read is ever issued. `o_fifo_read` is never asserted while `i_fifo_empty=1` is sampled in IDLE.
- **Reset mid-operation:** everything clears asynchronously, including busy flags and the counter. A command popped but not yet dispatched is lost. The owner of the PE array must reset the PEs together with this block.

## Structure
- `cmd_t` stays in the shared defines package, the same one the command queue uses.
- The dispatcher's FSM state enum (`disp_state_t`) is added to that package.
- One sub-module, `rr_arbiter #(N)`:
  - Inputs: `req[N]` (which is `~busy`) and `last[$clog2(N)]`.
  - Output: a one-hot `gnt[N]`.
  - It is purely combinational.
- Busy flags, `last_grant`, the counter and the FSM live in `cmd_dispatcher`.

## Test plan
- **Reset:** hold `i_rstn=0` and drive random inputs, then release. Required: all outputs at their reset values and `o_idle=1`. No `o_fifo_read` while `i_fifo_empty=1`.
- **Single command:** queue holds `cmd_t` A and `NUM_PE=4`, all free.
  - `o_fifo_read` is high exactly 1 cycle.
  - 2 cycles later `o_pe_valid=4'b0001` and `o_pe_cmd=A`.
  - `o_pe_busy=4'b0001` and `o_dispatch_count=1`.
- **Round-robin with saturation:** push 5 commands and send no done pulses.
  - Grants are 0001, 0010, 0100, 1000, then the FSM stalls in IDLE with the queue non-empty.
  - Pulse `i_pe_done[2]`. The 5th command goes to PE2 with `o_pe_valid` 4 cycles after the pulse.
- **Done/grant collision:**
  - With PE1 free and next in round-robin, assert `i_pe_done[1]` in the DISPATCH cycle. Required: `o_pe_busy[1]=1` afterwards.
  - Assert done on an already free PE. Required: no state change.
- **Counter wrap:** with `CNT_W=4`, dispatch 17 commands. Required: `o_dispatch_count=1`.
- **Reset mid-operation:** assert `i_rstn=0` during LOAD. Required: outputs clear immediately, with no `o_pe_valid` for that command after release.
